reg_load_sequencer: RTL

Multicycle control sequencer that drives the active-low load strobes of the datapath registers (IR, A, B, ALUOut, MDR, PC) and the register-file write strobe, one instruction at a time. It sits between the instruction decoder and the negedge-loading datapath registers. It updates on posedge, so every strobe is stable for the following negedge load. It also tracks memory wait states with a bounded timeout.

---
 rtl/reg_load_sequencer_pkg.sv | 44 ++++
 rtl/reg_load_sequencer_wait_timer.sv | 50 +++++
 rtl/reg_load_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/reg_load_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reg_seq_pkg
//  Purpose  : Shared types and constants for the register-load sequencer:
//             decoded instruction classes, sequencer state encoding and the
//             polarity of the active-low load strobes.
//  Revision : 1.0  initial release
// ============================================================================
package reg_seq_pkg;

  // Decoded instruction class delivered by the decoder; codes 5..7 are illegal
  typedef enum logic [2:0] {
    ALU    = 3'd0,
    LOAD   = 3'd1,
    STORE  = 3'd2,
    BRANCH = 3'd3,
    JUMP   = 3'd4
  } opclass_t;

  // Sequencer states; the encoding is exported on state_o for debug
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    DECODE   = 3'd2,
    EXECUTE  = 3'd3,
    MEM      = 3'd4,
    WB       = 3'd5,
    COMPLETE = 3'd6
  } state_t;

  // Load strobes into the datapath are active low
  localparam logic STROBE_OFF = 1'b1;
  localparam logic STROBE_ON  = 1'b0;

  // Highest legal opclass code
  localparam logic [2:0] OPCLASS_MAX = 3'd4;

  // True for the five defined instruction classes
  function automatic logic opclass_legal(input logic [2:0] code);
    return (code <= OPCLASS_MAX);
  endfunction

endpackage : reg_seq_pkg
`default_nettype wire

// File: rtl/reg_load_sequencer_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module   : wait_timer
//  Purpose  : Saturating wait-state counter with synchronous clear and count
//             enable. expired_o is high while the count equals LIMIT; the
//             count holds at LIMIT and never wraps.
//  Revision : 1.0  initial release
// ============================================================================
module wait_timer #(
  parameter int LIMIT = 16,
  parameter int WIDTH = 5
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [WIDTH-1:0] LIMIT_C = WIDTH'(LIMIT);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             at_limit;

  assign at_limit = (count_q == LIMIT_C);

  // Next count: clear has priority, then increment unless already saturated
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && !at_limit) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register with asynchronous reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = at_limit;

endmodule : wait_timer
`default_nettype wire

// File: rtl/reg_load_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : reg_load_sequencer
//  Purpose  : Multicycle control sequencer producing the active-low load
//             strobes for IR, A, B, ALUOut, MDR, PC and the register file.
//             State advances on posedge so every strobe is settled for the
//             negedge load of the datapath registers. Memory waits in FETCH
//             and MEM are bounded by MEM_TIMEOUT.
//  Revision : 1.0  initial release
// ============================================================================
module reg_load_sequencer
  import reg_seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TMR_WIDTH   = 5
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [2:0] opclass_i,
  input  logic       mem_ready_i,
  input  logic       branch_taken_i,
  output logic       ir_ld_no,
  output logic       a_ld_no,
  output logic       b_ld_no,
  output logic       alu_ld_no,
  output logic       mdr_ld_no,
  output logic       pc_ld_no,
  output logic       rf_wr_no,
  output logic       pc_sel_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       fault_o,
  output logic [2:0] state_o
);

  state_t   state_q;
  opclass_t opclass_q;
  logic     pc_sel_q;

  logic     waiting;
  logic     tmr_clr;
  logic     tmr_en;
  logic     tmr_expired;
  logic     wait_fault;
  logic     class_fault;

  // FETCH and MEM are the only states that stall on memory
  assign waiting = (state_q == FETCH) || (state_q == MEM);

  // The counter runs only while stalled; any ready or other state restarts it
  assign tmr_clr = !waiting || mem_ready_i;
  assign tmr_en  = waiting && !mem_ready_i;

  wait_timer #(
    .LIMIT (MEM_TIMEOUT),
    .WIDTH (TMR_WIDTH)
  ) u_wait_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (tmr_clr),
    .en_i      (tmr_en),
    .expired_o (tmr_expired)
  );

  // Ready in the same cycle the limit is reached wins over the timeout
  assign wait_fault  = waiting && !mem_ready_i && tmr_expired;
  assign class_fault = (state_q == DECODE) && !opclass_legal(opclass_i);

  // Sequencer: one instruction at a time; opclass and PC source are latched
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      opclass_q <= ALU;
      pc_sel_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= FETCH;
          end
        end

        FETCH: begin
          if (mem_ready_i) begin
            state_q <= DECODE;
          end else if (tmr_expired) begin
            state_q <= IDLE;
          end
        end

        DECODE: begin
          if (opclass_legal(opclass_i)) begin
            opclass_q <= opclass_t'(opclass_i);
            state_q   <= EXECUTE;
          end else begin
            state_q   <= IDLE;
          end
        end

        EXECUTE: begin
          case (opclass_q)
            ALU: begin
              pc_sel_q <= 1'b0;
              state_q  <= WB;
            end
            JUMP: begin
              pc_sel_q <= 1'b1;
              state_q  <= WB;
            end
            LOAD, STORE: begin
              pc_sel_q <= 1'b0;
              state_q  <= MEM;
            end
            BRANCH: begin
              pc_sel_q <= branch_taken_i;
              state_q  <= COMPLETE;
            end
            default: begin
              state_q  <= IDLE;
            end
          endcase
        end

        MEM: begin
          if (mem_ready_i) begin
            state_q <= (opclass_q == LOAD) ? WB : COMPLETE;
          end else if (tmr_expired) begin
            state_q <= IDLE;
          end
        end

        WB: begin
          state_q <= COMPLETE;
        end

        COMPLETE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Strobes decode straight from the state register so an asynchronous reset
  // drops them at once; only the memory-fed loads also wait for ready.
  assign ir_ld_no  = (state_q == FETCH && mem_ready_i)    ? STROBE_ON : STROBE_OFF;
  assign a_ld_no   = (state_q == DECODE)                  ? STROBE_ON : STROBE_OFF;
  assign b_ld_no   = (state_q == DECODE)                  ? STROBE_ON : STROBE_OFF;
  assign alu_ld_no = (state_q == EXECUTE)                 ? STROBE_ON : STROBE_OFF;
  assign mdr_ld_no = (state_q == MEM && mem_ready_i &&
                      opclass_q == LOAD)                  ? STROBE_ON : STROBE_OFF;
  assign rf_wr_no  = (state_q == WB)                      ? STROBE_ON : STROBE_OFF;
  assign pc_ld_no  = (state_q == COMPLETE)                ? STROBE_ON : STROBE_OFF;

  assign pc_sel_o  = pc_sel_q;
  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == COMPLETE);
  assign fault_o   = class_fault || wait_fault;
  assign state_o   = state_q;

endmodule : reg_load_sequencer
`default_nettype wire
